// File: rtl/program_memory.sv
// program_memory: parametrised instruction store with combinational read, direct write,
// streaming loader (auto-increment pointer, valid/ready) and a multi-cycle clear sweep. Optional parity: PROGRAM_MEMORY_PARITY_EN.
module program_memory #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    rd_index,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_index,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             st_valid,
    input  logic [WIDTH-1:0] st_data,
    input  logic             st_last,
    output logic             st_ready,
    input  logic             clear,
    output logic             busy,
    output logic [AW:0]      count,
    output logic             full,
`ifdef PROGRAM_MEMORY_PARITY_EN
    input  logic             par_inject,
    output logic             parity_err,
`endif
    output logic             loaded
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [AW-1:0]      clr_ptr_q, clr_ptr_d;
    logic [AW-1:0]      ld_ptr_q, ld_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               loaded_q, loaded_d;
    logic               accept;
    logic               wr_ok;
    logic               rd_in_range;
`ifdef PROGRAM_MEMORY_PARITY_EN
    logic               par_q [DEPTH];
    logic               par_d [DEPTH];
`endif

    assign full        = (count_q == DEPTH_W);
    assign st_ready    = (state_q == IDLE) && !full && !clear;
    assign accept      = st_valid && st_ready;
    assign wr_ok       = wr_en && ({1'b0, wr_index} < DEPTH_W);
    assign rd_in_range = ({1'b0, rd_index} < DEPTH_W);
    assign rd_data     = rd_in_range ? mem_q[rd_index] : '0;
    assign busy        = (state_q == CLEAR);
    assign count       = count_q;
    assign loaded      = loaded_q;
`ifdef PROGRAM_MEMORY_PARITY_EN
    assign parity_err  = rd_in_range ? (^{mem_q[rd_index], par_q[rd_index]}) : 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        clr_ptr_d = clr_ptr_q;
        ld_ptr_d  = ld_ptr_q;
        count_d   = count_q;
        loaded_d  = loaded_q;
`ifdef PROGRAM_MEMORY_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                // Direct write first so a same-address stream beat overrides it.
                if (wr_ok) begin
                    mem_d[wr_index] = wr_data;
`ifdef PROGRAM_MEMORY_PARITY_EN
                    par_d[wr_index] = (^wr_data) ^ par_inject;
`endif
                end
                if (clear) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                    ld_ptr_d  = '0;
                    count_d   = '0;
                    loaded_d  = 1'b0;
                end else if (accept) begin
                    mem_d[ld_ptr_q] = st_data;
`ifdef PROGRAM_MEMORY_PARITY_EN
                    par_d[ld_ptr_q] = (^st_data) ^ par_inject;
`endif
                    count_d = count_q + (AW+1)'(1);
                    if (st_last) begin
                        loaded_d = 1'b1;
                        ld_ptr_d = '0;
                    end else begin
                        ld_ptr_d = ld_ptr_q + AW'(1);
                    end
                end
            end
            CLEAR: begin
                mem_d[clr_ptr_q] = '0;
`ifdef PROGRAM_MEMORY_PARITY_EN
                par_d[clr_ptr_q] = 1'b0;
`endif
                clr_ptr_d = clr_ptr_q + AW'(1);
                if (clr_ptr_q == LAST_IDX) begin
                    state_d   = IDLE;
                    clr_ptr_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mem_q     <= '{default: '0};
            clr_ptr_q <= '0;
            ld_ptr_q  <= '0;
            count_q   <= '0;
            loaded_q  <= 1'b0;
`ifdef PROGRAM_MEMORY_PARITY_EN
            par_q     <= '{default: 1'b0};
`endif
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            clr_ptr_q <= clr_ptr_d;
            ld_ptr_q  <= ld_ptr_d;
            count_q   <= count_d;
            loaded_q  <= loaded_d;
`ifdef PROGRAM_MEMORY_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_program_memory.sv
// Self-checking bench for program_memory: behavioural model plus directed and random stimulus.
module tb_program_memory;
    localparam int WIDTH = 12;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [AW-1:0]    rd_index = '0;
    logic [WIDTH-1:0] rd_data;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_index = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             st_valid = 1'b0;
    logic [WIDTH-1:0] st_data = '0;
    logic             st_last = 1'b0;
    logic             st_ready;
    logic             clear = 1'b0;
    logic             busy;
    logic [AW:0]      count;
    logic             full;
    logic             loaded;
    logic             par_inject = 1'b0;
`ifdef PROGRAM_MEMORY_PARITY_EN
    logic             parity_err;
`endif

    program_memory #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .rd_index(rd_index), .rd_data(rd_data),
        .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
        .st_valid(st_valid), .st_data(st_data), .st_last(st_last), .st_ready(st_ready),
        .clear(clear), .busy(busy), .count(count), .full(full),
`ifdef PROGRAM_MEMORY_PARITY_EN
        .par_inject(par_inject), .parity_err(parity_err),
`endif
        .loaded(loaded)
    );

    always #50 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit started  = 1'b0;

    // Reference model: word array, remaining sweep words, load pointer and counters.
    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_par [DEPTH];
    int               sweep_left = 0;
    int               m_ptr = 0;
    int               m_count = 0;
    bit               m_loaded = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return (sweep_left == 0) && (m_count != DEPTH) && !clear;
    endfunction

    always @(posedge clk) begin : model
        bit rdy;
        rdy = model_ready();
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = '0;
                m_par[i] = 1'b0;
            end
            sweep_left = 0;
            m_ptr      = 0;
            m_count    = 0;
            m_loaded   = 1'b0;
        end else if (sweep_left > 0) begin
            m_mem[DEPTH - sweep_left] = '0;
            m_par[DEPTH - sweep_left] = 1'b0;
            sweep_left--;
        end else begin
            if (wr_en && int'(wr_index) < DEPTH) begin
                m_mem[wr_index] = wr_data;
                m_par[wr_index] = (^wr_data) ^ par_inject;
            end
            if (clear) begin
                sweep_left = DEPTH;
                m_ptr      = 0;
                m_count    = 0;
                m_loaded   = 1'b0;
            end else if (st_valid && rdy) begin
                m_mem[m_ptr] = st_data;
                m_par[m_ptr] = (^st_data) ^ par_inject;
                m_count++;
                if (st_last) begin
                    m_loaded = 1'b1;
                    m_ptr    = 0;
                end else begin
                    m_ptr++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("rd_data", 32'(rd_data), (int'(rd_index) < DEPTH) ? 32'(m_mem[rd_index]) : 32'd0);
            check("st_ready", 32'(st_ready), 32'(model_ready()));
            check("busy", 32'(busy), 32'(sweep_left > 0));
            check("count", 32'(count), 32'(m_count));
            check("full", 32'(full), 32'(m_count == DEPTH));
            check("loaded", 32'(loaded), 32'(m_loaded));
`ifdef PROGRAM_MEMORY_PARITY_EN
            check("parity_err", 32'(parity_err),
                  (int'(rd_index) < DEPTH) ? 32'((^m_mem[rd_index]) ^ m_par[rd_index]) : 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input int idx, input int val, input string name);
        rd_index = AW'(idx);
        #1;
        check(name, 32'(rd_data), 32'(val));
    endtask

    initial begin
        tick();
        started = 1'b1;
        tick();
        reset = 1'b0;

        // Reset state
        for (int i = 0; i < DEPTH; i++) expect_rd(i, 0, "reset_rd");
        check("reset_count", 32'(count), 32'd0);
        check("reset_loaded", 32'(loaded), 32'd0);
        check("reset_st_ready", 32'(st_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);

        // Direct writes, readback, reset wipes
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_index = AW'(i); wr_data = WIDTH'(i);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) expect_rd(i, i, "direct_rd");
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) expect_rd(i, 0, "post_reset_rd");

        // Full program stream with st_last on the final beat
        for (int i = 0; i < DEPTH; i++) begin
            st_valid = 1'b1; st_data = WIDTH'(12'h100 + i); st_last = (i == DEPTH - 1);
            tick();
        end
        st_valid = 1'b0; st_last = 1'b0;
        check("stream_count", 32'(count), 32'd8);
        check("stream_full", 32'(full), 32'd1);
        check("stream_loaded", 32'(loaded), 32'd1);
        check("stream_st_ready", 32'(st_ready), 32'd0);
        for (int i = 0; i < DEPTH; i++) expect_rd(i, 12'h100 + i, "stream_rd");
        st_valid = 1'b1; st_data = 12'hBAD;
        #1 check("ninth_st_ready", 32'(st_ready), 32'd0);
        tick();
        st_valid = 1'b0;
        check("ninth_count", 32'(count), 32'd8);
        expect_rd(0, 12'h100, "ninth_rd0");

        // Partial stream then clear sweep; direct writes ignored during sweep
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1; st_data = WIDTH'(12'h200 + i);
            tick();
        end
        st_valid = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        check("clear_count", 32'(count), 32'd0);
        check("clear_loaded", 32'(loaded), 32'd0);
        wr_en = 1'b1; wr_index = '0; wr_data = 12'hFFF;
        for (int k = 0; k < DEPTH; k++) begin
            check("sweep_busy", 32'(busy), 32'd1);
            expect_rd(k, (k < 3) ? 12'h200 + k : 0, "sweep_rd_before");
            tick();
        end
        wr_en = 1'b0;
        check("sweep_done_busy", 32'(busy), 32'd0);
        check("sweep_done_st_ready", 32'(st_ready), 32'd1);
        for (int i = 0; i < DEPTH; i++) expect_rd(i, 0, "sweep_done_rd");

        // Same-cycle direct write and stream beat
        wr_en = 1'b1; wr_index = 3'd0; wr_data = 12'hAAA;
        st_valid = 1'b1; st_data = 12'h555;
        tick();
        wr_index = 3'd5; wr_data = 12'h0AB; st_data = 12'h123;
        tick();
        wr_en = 1'b0; st_valid = 1'b0;
        expect_rd(0, 12'h555, "collide_rd0");
        expect_rd(1, 12'h123, "diff_rd1");
        expect_rd(5, 12'h0AB, "diff_rd5");
        check("collide_count", 32'(count), 32'd2);

        // clear beats st_valid
        clear = 1'b1; st_valid = 1'b1; st_data = 12'h777;
        #1 check("clear_vs_beat_ready", 32'(st_ready), 32'd0);
        tick();
        clear = 1'b0; st_valid = 1'b0;
        check("clear_vs_beat_busy", 32'(busy), 32'd1);
        expect_rd(2, 0, "clear_vs_beat_rd2");

        // Reset mid-sweep
        tick(); tick(); tick();
        expect_rd(5, 12'h0AB, "midsweep_rd5");
        reset = 1'b1; tick(); reset = 1'b0;
        check("midsweep_reset_busy", 32'(busy), 32'd0);
        check("midsweep_reset_st_ready", 32'(st_ready), 32'd1);
        for (int i = 0; i < DEPTH; i++) expect_rd(i, 0, "midsweep_reset_rd");

`ifdef PROGRAM_MEMORY_PARITY_EN
        wr_en = 1'b1; wr_index = 3'd3; wr_data = 12'h007; par_inject = 1'b1;
        tick();
        wr_index = 3'd4; par_inject = 1'b0;
        tick();
        wr_en = 1'b0;
        rd_index = 3'd3;
        #1 check("par_inject_err", 32'(parity_err), 32'd1);
        rd_index = 3'd4;
        #1 check("par_clean_err", 32'(parity_err), 32'd0);
        reset = 1'b1; tick(); reset = 1'b0;
        rd_index = 3'd3;
        #1 check("par_reset_err", 32'(parity_err), 32'd0);
`endif

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 199) == 0);
            clear      = ($urandom_range(0, 39) == 0);
            wr_en      = ($urandom_range(0, 2) == 0);
            wr_index   = AW'($urandom);
            wr_data    = WIDTH'($urandom);
            st_valid   = ($urandom_range(0, 9) < 7);
            st_data    = WIDTH'($urandom);
            st_last    = ($urandom_range(0, 5) == 0);
            par_inject = ($urandom_range(0, 7) == 0);
            rd_index   = AW'($urandom);
            tick();
        end
        reset = 1'b0; clear = 1'b0; wr_en = 1'b0; st_valid = 1'b0; st_last = 1'b0; par_inject = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
